// File: rtl/wb_serve_block.sv
// rtl/wb_serve_block.sv - two-stage burst read responder for a prefetched block buffer
// Optional error reporting enabled by defining WB_SERVE_BLOCK_ERR_EN.
module wb_serve_block #(
  parameter int BSIZE = 24,
  parameter int BBITS = 5,
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cyc_i,
  input  logic             stb_i,
  input  logic             we_i,
  input  logic             bst_i,
  input  logic [BBITS-1:0] adr_i,
  output logic             ack_o,
  output logic             wat_o,
  output logic             err_o,
  output logic [WIDTH-1:0] dat_o,
  input  logic             valid_i,
  output logic             mem_re_o,
  output logic [BBITS-1:0] mem_adr_o,
  input  logic [WIDTH-1:0] mem_dat_i,
  output logic             done_o
);

  // One extra bit so BSIZE == 2**BBITS still compares correctly.
  localparam logic [BBITS:0]   LIMIT = (BBITS+1)'(BSIZE);
  localparam logic [BBITS-1:0] LAST  = BBITS'(BSIZE - 1);

  logic acc;
  logic legal;
  logic s1_live;
  logic s1_bad;
  logic s1_last;
  logic s1_ok;
  logic hit;
  logic unused_bst;

  assign unused_bst = bst_i;

  assign wat_o     = rst_i | ~valid_i;
  assign acc       = cyc_i & stb_i & ~wat_o;
  assign legal     = acc & ~we_i & ({1'b0, adr_i} < LIMIT);
  assign mem_re_o  = legal;
  assign mem_adr_o = adr_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      s1_live <= 1'b0;
      s1_bad  <= 1'b0;
      s1_last <= 1'b0;
    end else begin
      s1_live <= acc;
      s1_bad  <= ~legal;
      s1_last <= legal & (adr_i == LAST);
    end
  end

  // Dropping cyc_i kills the tag sitting in stage 1 before it can respond.
  assign s1_ok = s1_live & cyc_i;
  assign hit   = s1_ok & ~s1_bad;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_o  <= 1'b0;
      dat_o  <= '0;
      done_o <= 1'b0;
    end else begin
`ifdef WB_SERVE_BLOCK_ERR_EN
      ack_o  <= hit;
`else
      ack_o  <= s1_ok;
`endif
      dat_o  <= hit ? mem_dat_i : '0;
      done_o <= hit & s1_last;
    end
  end

`ifdef WB_SERVE_BLOCK_ERR_EN
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) err_o <= 1'b0;
    else       err_o <= s1_ok & s1_bad;
  end
`else
  assign err_o = 1'b0;
`endif

endmodule

// File: tb/tb_wb_serve_block.sv
// tb/tb_wb_serve_block.sv - scoreboard bench for wb_serve_block
// Expected responses are queued at issue time and checked by a negedge monitor.
module tb_wb_serve_block;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b1;
  logic       cyc_i = 1'b0;
  logic       stb_i = 1'b0;
  logic       we_i = 1'b0;
  logic       bst_i = 1'b0;
  logic [4:0] adr_i = '0;
  logic       ack_o;
  logic       wat_o;
  logic       err_o;
  logic [7:0] dat_o;
  logic       valid_i = 1'b1;
  logic       mem_re_o;
  logic [4:0] mem_adr_o;
  logic [7:0] mem_dat_i = '0;
  logic       done_o;

  wb_serve_block #(.BSIZE(24), .BBITS(5), .WIDTH(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .cyc_i(cyc_i), .stb_i(stb_i), .we_i(we_i),
    .bst_i(bst_i), .adr_i(adr_i), .ack_o(ack_o), .wat_o(wat_o), .err_o(err_o),
    .dat_o(dat_o), .valid_i(valid_i), .mem_re_o(mem_re_o), .mem_adr_o(mem_adr_o),
    .mem_dat_i(mem_dat_i), .done_o(done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    int         due;
    logic       ack;
    logic       err;
    logic [7:0] dat;
    logic       done;
  } exp_t;

  exp_t sb[$];
  int   cyc_n = 0;
  int   total = 0;
  int   bad = 0;

`ifdef WB_SERVE_BLOCK_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  function automatic logic [7:0] rom(input logic [4:0] a);
    return 8'(a * 7 + 8'h31);
  endfunction

  always @(posedge clk_i) begin
    cyc_n <= cyc_n + 1;
    if (mem_re_o) mem_dat_i <= rom(mem_adr_o);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc_n);
    end
  endtask

  // Monitor: every response must match the head of the scoreboard on its due cycle.
  always @(negedge clk_i) begin
    if (!rst_i) begin
      while (sb.size() > 0 && sb[0].due < cyc_n) begin
        chk("missing_response", 32'(sb[0].due), 32'(cyc_n));
        void'(sb.pop_front());
      end
      if (ack_o || err_o || done_o) begin
        if (sb.size() == 0 || sb[0].due != cyc_n) begin
          chk("unexpected_response", {29'd0, ack_o, err_o, done_o}, 32'd0);
        end else begin
          chk("ack", 32'(ack_o), 32'(sb[0].ack));
          chk("err", 32'(err_o), 32'(sb[0].err));
          chk("dat", 32'(dat_o), 32'(sb[0].dat));
          chk("done", 32'(done_o), 32'(sb[0].done));
          void'(sb.pop_front());
        end
      end
    end
  end

  task automatic drive(input logic c, input logic s, input logic w,
                       input logic [4:0] a, output logic took);
    logic lg;
    exp_t e;
    cyc_i = c;
    stb_i = s;
    we_i  = w;
    bst_i = s;
    adr_i = a;
    took  = c && s && valid_i && !rst_i;
    lg    = took && !w && (a < 5'd24);
    if (!c) begin
      for (int i = sb.size() - 1; i >= 0; i--)
        if (sb[i].due > cyc_n) sb.delete(i);
    end
    if (took) begin
      e.due  = cyc_n + 2;
      e.ack  = lg || !ERR_EN;
      e.err  = !lg && ERR_EN;
      e.dat  = lg ? rom(a) : 8'h00;
      e.done = lg && (a == 5'd23);
      sb.push_back(e);
    end
    #1;
    chk("wat_o", 32'(wat_o), 32'(rst_i || !valid_i));
    chk("mem_re_o", 32'(mem_re_o), 32'(lg));
    if (lg) chk("mem_adr_o", 32'(mem_adr_o), 32'(a));
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    logic t;
    for (int i = 0; i < n; i++) drive(1'b1, 1'b0, 1'b0, 5'd0, t);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc_n);
    $fatal(1);
  end

  initial begin
    logic took;
    int   a;
    int   n;

    // Reset state, with a request presented while reset is held.
    cyc_i = 1'b1; stb_i = 1'b1;
    #1;
    chk("rst_ack", 32'(ack_o), 32'd0);
    chk("rst_err", 32'(err_o), 32'd0);
    chk("rst_done", 32'(done_o), 32'd0);
    chk("rst_dat", 32'(dat_o), 32'd0);
    chk("rst_wat", 32'(wat_o), 32'd1);
    chk("rst_mem_re", 32'(mem_re_o), 32'd0);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(2);

    // Full burst 0..23.
    a = 0;
    while (a < 24) begin
      drive(1'b1, 1'b1, 1'b0, a[4:0], took);
      if (took) a++;
    end
    idle(4);

    // Stall: valid_i low for 5 cycles mid-burst; master re-issues.
    a = 0; n = 0;
    while (a < 10) begin
      valid_i = !(n >= 4 && n < 9);
      drive(1'b1, 1'b1, 1'b0, a[4:0], took);
      if (took) a++;
      n++;
    end
    valid_i = 1'b1;
    idle(4);

    // Abort: cyc_i drops the cycle after a request for adr 3.
    drive(1'b1, 1'b1, 1'b0, 5'd3, took);
    drive(1'b0, 1'b0, 1'b0, 5'd0, took);
    drive(1'b1, 1'b1, 1'b0, 5'd0, took);
    drive(1'b1, 1'b1, 1'b0, 5'd1, took);
    idle(4);

    // Illegal requests: out-of-range read, then a write.
    drive(1'b1, 1'b1, 1'b0, 5'd24, took);
    idle(2);
    drive(1'b1, 1'b1, 1'b1, 5'd5, took);
    idle(2);
    drive(1'b1, 1'b1, 1'b0, 5'd31, took);
    idle(4);

    // Async reset with two requests in flight.
    drive(1'b1, 1'b1, 1'b0, 5'd10, took);
    drive(1'b1, 1'b1, 1'b0, 5'd11, took);
    drive(1'b1, 1'b1, 1'b0, 5'd23, took);
    stb_i = 1'b0;
    #2;
    rst_i = 1'b1;
    sb.delete();
    #1;
    chk("arst_ack", 32'(ack_o), 32'd0);
    chk("arst_err", 32'(err_o), 32'd0);
    chk("arst_done", 32'(done_o), 32'd0);
    chk("arst_wat", 32'(wat_o), 32'd1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    idle(5);

    // Isolated reads of the last word with gaps.
    drive(1'b1, 1'b1, 1'b0, 5'd23, took);
    idle(3);
    drive(1'b1, 1'b1, 1'b0, 5'd23, took);
    idle(4);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
